// File: rtl/divide_seq_if.sv
// rtl/divide_seq_if.sv - request/result bundle between a divide_seq requester and the divider
interface divide_seq_if #(
    parameter int DIVIDEND_W = 4,
    parameter int DIVISOR_W  = 2
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divide_seq.sv
// rtl/divide_seq.sv - sequential restoring divider, one quotient bit per clock (option: DIVIDER_ZERO_CHECK_EN)
module divide_seq #(
    parameter int DIVIDEND_W = 4,
    parameter int DIVISOR_W  = 2
) (
    input  logic          clk,
    input  logic          rst,
    divide_seq_if.slave   bus
);
    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DIVIDEND_W-1:0] q_q, q_d;
    logic [DIVISOR_W-1:0]  d_q, d_d;
    // The partial remainder is always < divisor after each step, so its top
    // bit is always zero between iterations; only the shifted value needs it.
    logic [DIVISOR_W-1:0]  r_q, r_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  accept;
    logic                  last_iter;
    logic [DIVISOR_W:0]    r_shift;
    logic                  r_ge;
    logic [DIVISOR_W-1:0]  r_next;

    assign accept    = (state_q == IDLE) && bus.start;
    assign last_iter = (cnt_q == CNT_W'(DIVIDEND_W - 1));

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            d_q         <= d_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
`ifdef DIVIDER_ZERO_CHECK_EN
                    state_d = (bus.divisor == '0) ? DONE : CALC;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC:    if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        r_shift = {r_q, q_q[DIVIDEND_W-1]};
        r_ge    = (r_shift >= {1'b0, d_q});
        // When the subtraction happens the true result is < divisor, so the
        // narrow modular difference is exact.
        r_next  = r_ge ? (r_shift[DIVISOR_W-1:0] - d_q) : r_shift[DIVISOR_W-1:0];
    end

    // Datapath register updates
    always_comb begin
        q_d         = q_q;
        d_d         = d_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        if (accept) begin
            q_d   = bus.dividend;
            d_d   = bus.divisor;
            r_d   = '0;
            cnt_d = '0;
`ifdef DIVIDER_ZERO_CHECK_EN
            if (bus.divisor == '0) begin
                quotient_d  = '1;
                remainder_d = '0;
            end
`endif
        end else if (state_q == CALC) begin
            q_d   = {q_q[DIVIDEND_W-2:0], r_ge};
            r_d   = r_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_iter) begin
                quotient_d  = {q_q[DIVIDEND_W-2:0], r_ge};
                remainder_d = r_next;
            end
        end
    end

    // Status outputs are registered from the next state
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

`ifdef DIVIDER_ZERO_CHECK_EN
    logic dbz_q, dbz_d;

    // Divide-by-zero flag: set on the fast path, cleared by any normal result
    always_comb begin
        dbz_d = dbz_q;
        if (accept && (bus.divisor == '0)) begin
            dbz_d = 1'b1;
        end else if ((state_q == CALC) && last_iter) begin
            dbz_d = 1'b0;
        end
    end

    // Divide-by-zero flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            dbz_q <= 1'b0;
        end else begin
            dbz_q <= dbz_d;
        end
    end

    assign bus.div_by_zero = dbz_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
endmodule

// File: tb/tb_divide_seq.sv
// tb/tb_divide_seq.sv - directed self-checking bench for divide_seq
module tb_divide_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    divide_seq_if #(.DIVIDEND_W(4), .DIVISOR_W(2)) bus ();

    divide_seq #(.DIVIDEND_W(4), .DIVISOR_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance until done is seen (sampled #1 after each edge); n = edges waited.
    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run(input string tag, input logic [3:0] a, input logic [1:0] b,
                       input logic [3:0] eq, input logic [1:0] er, input logic edbz,
                       input int elat);
        int n;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_done(n);
        check({tag, "_lat"}, 32'(n), 32'(elat));
        check({tag, "_q"}, 32'(bus.quotient), 32'(eq));
        check({tag, "_r"}, 32'(bus.remainder), 32'(er));
        check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(edbz));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        check({tag, "_q_held"}, 32'(bus.quotient), 32'(eq));
    endtask

    initial begin
        int n;
        int pulses;
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_q", 32'(bus.quotient), 32'd0);
        check("rst_r", 32'(bus.remainder), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run("d15_2", 4'd15, 2'd2, 4'd7, 2'd1, 1'b0, 4);
        run("d9_3", 4'd9, 2'd3, 4'd3, 2'd0, 1'b0, 4);
        run("d2_3", 4'd2, 2'd3, 4'd0, 2'd2, 1'b0, 4);
        run("d15_1", 4'd15, 2'd1, 4'd15, 2'd0, 1'b0, 4);

        // start held high: second operands only taken after IDLE re-entry
        bus.start    = 1'b1;
        bus.dividend = 4'd15;
        bus.divisor  = 2'd2;
        @(posedge clk);
        #1;
        bus.dividend = 4'd9;
        bus.divisor  = 2'd3;
        wait_done(n);
        check("held_lat1", 32'(n), 32'd4);
        check("held_q1", 32'(bus.quotient), 32'd7);
        check("held_r1", 32'(bus.remainder), 32'd1);
        @(posedge clk);
        #1;
        check("held_done_once", 32'(bus.done), 32'd0);
        wait_done(n);
        bus.start = 1'b0;
        check("held_lat2", 32'(n), 32'd5);
        check("held_q2", 32'(bus.quotient), 32'd3);
        check("held_r2", 32'(bus.remainder), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        // reset two cycles into 14/3 aborts with no done
        bus.start    = 1'b1;
        bus.dividend = 4'd14;
        bus.divisor  = 2'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_q", 32'(bus.quotient), 32'd0);
        check("abort_r", 32'(bus.remainder), 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1) pulses++;
            @(posedge clk);
            #1;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        run("d14_3", 4'd14, 2'd3, 4'd4, 2'd2, 1'b0, 4);

`ifdef DIVIDER_ZERO_CHECK_EN
        run("d13_0", 4'd13, 2'd0, 4'd15, 2'd0, 1'b1, 0);
`else
        run("d13_0", 4'd13, 2'd0, 4'd15, 2'd1, 1'b0, 4);
`endif
        run("d7_2", 4'd7, 2'd2, 4'd3, 2'd1, 1'b0, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
